chien_search_seq: RTL and testbench
===================================

Name: chien_search_seq

Overview:
- Sequential, parametrised Chien search for binary BCH decoding over GF(2^M).
- Evaluates Λ(x) = 1 + λ1·x + … + λT·x^T at x = α^-i for i = 0..N-1, P positions per cycle.
- Sits after the Berlekamp/locator stage and before error correction.
- Successor to the fixed t=2, GF(16), combinational Chien evaluator. Adds start/done handshake, error counting and decode-failure detection.

Parameters:
- M, 4, field width in bits (GF(2^M)).
- PRIM_POLY, 5'b10011, primitive polynomial of width M+1 (x^4+x+1); α = 2.
- N, 15, code length. Must satisfy N ≤ 2^M-1.
- T, 2, maximum correctable errors (locator degree).
- P, 1, positions evaluated per cycle. Must satisfy 1 ≤ P ≤ N.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  begin search; sampled only in IDLE.
- lambda  in  T*M  packed coefficients; λj occupies bits [j*M-1:(j-1)*M], j = 1..T. λ0 = 1 is implied.
- deg  in  $clog2(T+1)  degree of the locator polynomial.
- busy  out  1  high while a search is in progress.
- done  out  1  one-cycle pulse when results are valid.
- error_vector  out  N  bit i set when Λ(α^-i) = 0.
- err_count  out  $clog2(N+1)  number of roots found.
- fail  out  1  decode failure flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, error_vector=0, err_count=0, fail=0; all term registers 0.
- FSM states and transitions:
  - IDLE: start=1 → latch deg; load r_j=λj for j=1..T; clear error_vector and err_count; go to EVAL with block index k=0.
  - EVAL: lane p (0..P-1) evaluates position i=k*P+p as S = 1 ⊕ Σ_j r_j·α^(-j·p). S==0 → set error_vector[i] and increment err_count. Then r_j ← r_j·α^(-j·P) and k ← k+1.
  - Lane masking: lanes with i ≥ N (last partial block) are masked and never set bits.
  - EVAL exit: after ceil(N/P) EVAL cycles → DONE.
  - DONE: done=1 for exactly one cycle; fail computed; → IDLE.
- Constant multipliers: all α powers are elaboration-time constants reduced mod 2^M-1 (α^-j = α^(2^M-1-j)). Constant GF multipliers are XOR networks. No log/antilog tables.
- Latency: start sampled at edge E → done high in the cycle after edge E+ceil(N/P)+1. Example: N=15, P=1 gives done 16 cycles after the start edge.
- busy: high from the edge after start through the DONE cycle.
- start while busy: ignored; no restart, no error.
- Outputs hold: error_vector, err_count and fail hold their values until the next accepted start, which clears them.
- fail = (err_count != deg), registered in DONE.
  - deg > T → fail=1 regardless of roots.
  - deg=0 → no roots expected; fail=0 when err_count=0.
- λ values above degree deg are used as supplied; they are not masked.
- Reset mid-search: immediate return to IDLE with all outputs 0; no done pulse.
- Widths: err_count saturates by construction (maximum N). Arithmetic is GF(2^M), all XOR.

Optional Feature:
- CHIEN_EARLY_TERM_EN defined:
  - In EVAL, once err_count (including the current cycle's hits) equals deg and deg ≥ 1, go to DONE on the next edge.
  - Remaining error_vector bits stay 0; fail=0.
  - Latency is variable; the minimum is 2 cycles after the start edge.
- Undefined: always a full ceil(N/P) EVAL cycles; fixed latency.

Decomposition:
- Shared package bch_gf_pkg:
  - GF width and field-order constants.
  - Default PRIM_POLY.
  - Constant functions: gf_alpha_pow(e), gf_mul_const(a, c), mod-(2^M-1) exponent reduction.
  - FSM state typedef (IDLE, EVAL, DONE).
- Sub-module gf_mult_const (parametrised by constant C and M): one instance per (j, lane) term and one per register update.

Test Plan:
- Two errors, N=15, T=2, P=1: λ1=15, λ2=13, deg=2 (errors at positions 3, 10) → error_vector=15'h0408, err_count=2, fail=0, done 16 cycles after the start edge.
- Single error: λ1=6, λ2=0, deg=1 → error_vector=15'h0020, err_count=1, fail=0.
- Failure case: λ1=0, λ2=1, deg=2 → error_vector=15'h0001, err_count=1, fail=1.
- P=4 with the two-error vector above → same outputs; done 5 cycles after the start edge; the masked lane (i=15) never fires.
- Control cases:
  - start pulsed mid-EVAL → ignored; results match the original search.
  - rst=0 at EVAL cycle 5 → all outputs 0 immediately; no done pulse.
  - Next start after reset → a correct run.
- With CHIEN_EARLY_TERM_EN, two-error vector → done 12 cycles after the start edge; outputs as in the first scenario.

Source files
------------

// File: rtl/bch_gf_pkg.sv
// Shared GF(2^M) helpers and FSM state type for the BCH Chien search.
// All functions are elaboration-time constant functions; no tables.
package bch_gf_pkg;

    localparam int MAX_M = 16;
    localparam int GF_M = 4;
    localparam int GF_ORDER = (1 << GF_M) - 1;
    localparam logic [GF_M:0] DEF_POLY = 5'b10011;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } chien_state_e;

    function automatic int gf_exp_mod(int e, int m);
        int ord;
        ord = (1 << m) - 1;
        return e % ord;
    endfunction

    // alpha^-e expressed as a non-negative exponent
    function automatic int gf_neg_exp(int e, int m);
        int ord;
        ord = (1 << m) - 1;
        return (ord - gf_exp_mod(e, m)) % ord;
    endfunction

    function automatic logic [MAX_M-1:0] gf_mul_const(
        logic [MAX_M-1:0] a,
        logic [MAX_M-1:0] c,
        int m,
        logic [MAX_M:0] poly
    );
        logic [MAX_M:0] x;
        logic [MAX_M-1:0] p;
        x = {1'b0, a};
        p = '0;
        for (int i = 0; i < m; i++) begin
            if (c[i]) p = p ^ x[MAX_M-1:0];
            x = x << 1;
            if (x[m]) x = x ^ poly;
        end
        return p;
    endfunction

    function automatic logic [MAX_M-1:0] gf_alpha_pow(
        int e,
        int m,
        logic [MAX_M:0] poly
    );
        logic [MAX_M-1:0] v;
        v = MAX_M'(1);
        for (int i = 0; i < gf_exp_mod(e, m); i++)
            v = gf_mul_const(v, MAX_M'(2), m, poly);
        return v;
    endfunction

endpackage

// File: rtl/gf_mult_const.sv
// Multiply by a fixed GF(2^M) constant C; pure XOR network.
// Each input bit selects one precomputed column C*alpha^b.
module gf_mult_const
    import bch_gf_pkg::*;
#(
    parameter int M = GF_M,
    parameter logic [M:0] PRIM_POLY = DEF_POLY,
    parameter logic [M-1:0] C = M'(1)
) (
    input  logic [M-1:0] a_i,
    output logic [M-1:0] y_o
);

    localparam logic [MAX_M:0] POLY_W = (MAX_M+1)'(PRIM_POLY);

    logic [M-1:0] part [M];

    for (genvar b = 0; b < M; b++) begin : g_col
        localparam logic [MAX_M-1:0] COL =
            gf_mul_const(MAX_M'(1) << b, MAX_M'(C), M, POLY_W);
        assign part[b] = a_i[b] ? COL[M-1:0] : '0;
    end

    always_comb begin
        y_o = '0;
        for (int b = 0; b < M; b++) y_o = y_o ^ part[b];
    end

endmodule

// File: rtl/chien_search_seq.sv
// Sequential Chien search, P positions per cycle, start/done handshake.
// Optional CHIEN_EARLY_TERM_EN: stop once err_count reaches deg.
module chien_search_seq
    import bch_gf_pkg::*;
#(
    parameter int M = GF_M,
    parameter logic [M:0] PRIM_POLY = DEF_POLY,
    parameter int N = 15,
    parameter int T = 2,
    parameter int P = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [T*M-1:0]           lambda,
    input  logic [$clog2(T+1)-1:0]   deg,
    output logic                     busy,
    output logic                     done,
    output logic [N-1:0]             error_vector,
    output logic [$clog2(N+1)-1:0]   err_count,
    output logic                     fail
);

    localparam int DW = $clog2(T+1);
    localparam int CW = $clog2(N+1);
    localparam int NB = (N + P - 1) / P;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [MAX_M:0] POLY_W = (MAX_M+1)'(PRIM_POLY);

    chien_state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [M-1:0] r_q [T];
    logic [M-1:0] r_d [T];
    logic [DW-1:0] deg_q, deg_d;
    logic [N-1:0] ev_q, ev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic fail_q, fail_d;
    logic done_q, done_d;

    logic [M-1:0] term [P][T];
    logic [M-1:0] upd [T];
    logic [P-1:0] hit;
    logic [CW-1:0] nhit;

    // lane p sees r_j scaled by alpha^(-j*p)
    for (genvar p = 0; p < P; p++) begin : g_lane
        for (genvar j = 0; j < T; j++) begin : g_term
            localparam logic [M-1:0] CT =
                M'(gf_alpha_pow(gf_neg_exp((j + 1) * p, M), M, POLY_W));
            gf_mult_const #(.M(M), .PRIM_POLY(PRIM_POLY), .C(CT)) u_term (
                .a_i(r_q[j]),
                .y_o(term[p][j])
            );
        end
    end

    for (genvar j = 0; j < T; j++) begin : g_upd
        localparam logic [M-1:0] CU =
            M'(gf_alpha_pow(gf_neg_exp((j + 1) * P, M), M, POLY_W));
        gf_mult_const #(.M(M), .PRIM_POLY(PRIM_POLY), .C(CU)) u_upd (
            .a_i(r_q[j]),
            .y_o(upd[j])
        );
    end

    always_comb begin
        logic [M-1:0] s;
        hit = '0;
        nhit = '0;
        for (int p = 0; p < P; p++) begin
            s = M'(1);
            for (int j = 0; j < T; j++) s = s ^ term[p][j];
            hit[p] = (s == '0) && ((int'(k_q) * P + p) < N);
            nhit = nhit + CW'(hit[p]);
        end
    end

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        r_d = r_q;
        deg_d = deg_q;
        ev_d = ev_q;
        cnt_d = cnt_q;
        fail_d = fail_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    deg_d = deg;
                    for (int j = 0; j < T; j++) r_d[j] = lambda[j*M +: M];
                    ev_d = '0;
                    cnt_d = '0;
                    fail_d = 1'b0;
                    k_d = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                for (int i = 0; i < N; i++)
                    for (int p = 0; p < P; p++)
                        if (hit[p] && (int'(k_q) * P + p) == i) ev_d[i] = 1'b1;
                cnt_d = cnt_q + nhit;
                r_d = upd;
                k_d = k_q + KW'(1);
                if (int'(k_q) == NB - 1) state_d = DONE;
`ifdef CHIEN_EARLY_TERM_EN
                if (deg_q != '0 && int'(deg_q) <= T &&
                    int'(cnt_d) == int'(deg_q))
                    state_d = DONE;
`endif
            end
            DONE: begin
                done_d = 1'b1;
                fail_d = (int'(cnt_q) != int'(deg_q)) || (int'(deg_q) > T);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q <= '0;
            for (int j = 0; j < T; j++) r_q[j] <= '0;
            deg_q <= '0;
            ev_q <= '0;
            cnt_q <= '0;
            fail_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            r_q <= r_d;
            deg_q <= deg_d;
            ev_q <= ev_d;
            cnt_q <= cnt_d;
            fail_q <= fail_d;
            done_q <= done_d;
        end
    end

    // busy spans the whole search including the done pulse
    assign busy = (state_q != IDLE) || done_q;
    assign done = done_q;
    assign error_vector = ev_q;
    assign err_count = cnt_q;
    assign fail = fail_q;

endmodule

// File: tb/tb_chien_search_seq.sv
// Scoreboard bench for chien_search_seq, P=1 and P=4 instances.
module tb_chien_search_seq;

    localparam int M = 4;
    localparam int N = 15;
    localparam int T = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s1 = 1'b0;
    logic s4 = 1'b0;
    logic [T*M-1:0] lambda = '0;
    logic [1:0] deg = '0;

    logic b1, d1, f1, b4, d4, f4;
    logic [N-1:0] ev1, ev4;
    logic [3:0] c1, c4;

    always #5 clk = ~clk;

    chien_search_seq #(.M(M), .N(N), .T(T), .P(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .lambda(lambda), .deg(deg),
        .busy(b1), .done(d1), .error_vector(ev1), .err_count(c1),
        .fail(f1)
    );

    chien_search_seq #(.M(M), .N(N), .T(T), .P(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .lambda(lambda), .deg(deg),
        .busy(b4), .done(d4), .error_vector(ev4), .err_count(c4),
        .fail(f4)
    );

    typedef struct {
        int ev;
        int cnt;
        int fl;
        int cyc;
    } exp_t;

    typedef struct {
        logic [3:0] l1;
        logic [3:0] l2;
        logic [1:0] dg;
        int ev;
        int cnt;
        int fl;
        int lat1;
        int lat4;
    } vec_t;

    exp_t q1[$];
    exp_t q4[$];
    vec_t V[6];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && d1) begin
            if (q1.size() == 0) chk("p1 spurious done", 1, 0);
            else begin
                e = q1.pop_front();
                chk("p1 error_vector", int'(ev1), e.ev);
                chk("p1 err_count", int'(c1), e.cnt);
                chk("p1 fail", int'(f1), e.fl);
                chk("p1 done cycle", cyc, e.cyc);
                chk("p1 busy at done", int'(b1), 1);
            end
        end
        if (rst && d4) begin
            if (q4.size() == 0) chk("p4 spurious done", 1, 0);
            else begin
                e = q4.pop_front();
                chk("p4 error_vector", int'(ev4), e.ev);
                chk("p4 err_count", int'(c4), e.cnt);
                chk("p4 fail", int'(f4), e.fl);
                chk("p4 done cycle", cyc, e.cyc);
                chk("p4 busy at done", int'(b4), 1);
            end
        end
    end

    task automatic go(int idx, bit en1, bit en4, bit push1);
        @(negedge clk);
        lambda = {V[idx].l2, V[idx].l1};
        deg = V[idx].dg;
        s1 = en1;
        s4 = en4;
        if (en1 && push1)
            q1.push_back('{V[idx].ev, V[idx].cnt, V[idx].fl,
                           cyc + 1 + V[idx].lat1});
        if (en4)
            q4.push_back('{V[idx].ev, V[idx].cnt, V[idx].fl,
                           cyc + 1 + V[idx].lat4});
        @(negedge clk);
        s1 = 1'b0;
        s4 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (q1.size() == 0 && q4.size() == 0) break;
            @(negedge clk);
        end
        chk("drain timeout", q1.size() + q4.size(), 0);
        q1.delete();
        q4.delete();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " p1 busy"}, int'(b1), 0);
        chk({tag, " p1 done"}, int'(d1), 0);
        chk({tag, " p1 error_vector"}, int'(ev1), 0);
        chk({tag, " p1 err_count"}, int'(c1), 0);
        chk({tag, " p1 fail"}, int'(f1), 0);
        chk({tag, " p4 busy"}, int'(b4), 0);
        chk({tag, " p4 error_vector"}, int'(ev4), 0);
        chk({tag, " p4 err_count"}, int'(c4), 0);
    endtask

    initial begin
`ifdef CHIEN_EARLY_TERM_EN
        V[0] = '{4'd15, 4'd13, 2'd2, 'h0408, 2, 0, 12, 4};
        V[1] = '{4'd6,  4'd0,  2'd1, 'h0020, 1, 0, 7,  3};
`else
        V[0] = '{4'd15, 4'd13, 2'd2, 'h0408, 2, 0, 16, 5};
        V[1] = '{4'd6,  4'd0,  2'd1, 'h0020, 1, 0, 16, 5};
`endif
        V[2] = '{4'd0,  4'd1,  2'd2, 'h0001, 1, 1, 16, 5};
        V[3] = '{4'd15, 4'd13, 2'd3, 'h0408, 2, 1, 16, 5};
        V[4] = '{4'd0,  4'd0,  2'd0, 'h0000, 0, 0, 16, 5};
        V[5] = '{4'd9,  4'd0,  2'd1, 'h4000, 1, 0, 16, 5};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            go(v, 1'b1, 1'b1, 1'b1);
            drain();
        end

        // start pulsed mid-EVAL with different coefficients
        go(0, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        lambda = {4'd1, 4'd0};
        deg = 2'd2;
        s1 = 1'b1;
        s4 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        s4 = 1'b0;
        drain();

        // reset in the middle of a P=1 search
        go(0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("p1 busy mid-run", int'(b1), 1);
        chk("p1 count mid-run", int'(c1), 1);
        rst = 1'b0;
        #1;
        chk_zero("mid-reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);

        go(1, 1'b1, 1'b1, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
